// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: register file plus issue sequencer in front of a registered ALU.
// One request is accepted at a time. Both operands are read from the register file
// at accept and held on the ALU inputs while the ALU result and its zero flag settle.
// The result is then written back and completion is reported with a one-cycle done
// pulse. Illegal opcodes complete on the next cycle with an error and no writeback.
module alu_issue_ctrl #(
  parameter int N      = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic [ADDR_W-1:0] req_src1,
  input  logic [ADDR_W-1:0] req_src2,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [N-1:0]      ld_data,
  output logic [N-1:0]      alu_in1,
  output logic [N-1:0]      alu_in2,
  output logic [2:0]        alu_op,
  input  logic [N-1:0]      alu_out,
  input  logic              alu_z,
  output logic              done,
  output logic              done_err,
  output logic [N-1:0]      done_data,
  output logic              zero_flag
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT1, WAIT2} state_t;

  state_t            state;
  state_t            state_next;
  logic [N-1:0]      rf [DEPTH];
  logic [ADDR_W-1:0] dst_q;
  logic              accept;
  logic              op_legal;
  logic              finish;

  // A pending load takes the slot, so requests wait while ld_en is high.
  assign req_ready = (state == IDLE) && !ld_en;
  assign accept    = req_valid && req_ready;
  assign op_legal  = (req_op <= 3'd4);
  assign finish    = (state == WAIT2);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: legal ops walk ISSUE -> WAIT1 -> WAIT2 -> IDLE; illegal ops never leave IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && op_legal) state_next = ISSUE;
      ISSUE:   state_next = WAIT1;
      WAIT1:   state_next = WAIT2;
      WAIT2:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Register file: direct loads only in IDLE, writeback when leaving WAIT2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (state == IDLE && ld_en) begin
      rf[ld_addr] <= ld_data;
    end else if (finish) begin
      rf[dst_q] <= alu_out;
    end
  end

  // Operands and opcode are captured at a legal accept and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_op  <= '0;
      dst_q   <= '0;
    end else if (accept && op_legal) begin
      alu_in1 <= rf[req_src1];
      alu_in2 <= rf[req_src2];
      alu_op  <= req_op;
      dst_q   <= req_dst;
    end
  end

  // Completion reporting: done pulses for one cycle; zero_flag only moves on legal completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      done_err  <= 1'b0;
      done_data <= '0;
      zero_flag <= 1'b0;
    end else begin
      done     <= 1'b0;
      done_err <= 1'b0;
      if (finish) begin
        done      <= 1'b1;
        done_data <= alu_out;
        zero_flag <= alu_z;
      end else if (accept && !op_legal) begin
        done      <= 1'b1;
        done_err  <= 1'b1;
        done_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl. Contains a registered ALU stub, a behavioural
// reference model (register array plus a remaining-latency count), a per-cycle
// compare process, directed scenarios with literal expectations and a random phase.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [2:0]  req_dst = '0;
  logic [2:0]  req_src1 = '0;
  logic [2:0]  req_src2 = '0;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [2:0]  alu_op;
  logic [15:0] alu_out = '0;
  logic        alu_z = 1'b0;
  logic        done;
  logic        done_err;
  logic [15:0] done_data;
  logic        zero_flag;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  alu_issue_ctrl #(.N(16), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_dst(req_dst), .req_src1(req_src1), .req_src2(req_src2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z),
    .done(done), .done_err(done_err), .done_data(done_data), .zero_flag(zero_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ALU semantics used by both the stub and the reference model.
  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] r;
    case (op)
      3'd0:    r = a;
      3'd1:    r = a + b;
      3'd2:    r = a - b;
      3'd3:    r = a * b;
      3'd4:    r = a << b[3:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  // Registered ALU stub: result one cycle after operands, zero flag one cycle after result.
  always @(posedge clk) begin
    alu_out <= alu_fn(alu_op, alu_in1, alu_in2);
    alu_z   <= (alu_out == 16'd0);
  end

  // Reference model state.
  logic [15:0] m_regs [8];
  int          m_cnt;
  logic [2:0]  m_dst;
  logic [15:0] m_result;
  logic [15:0] m_in1, m_in2;
  logic [2:0]  m_op;
  logic        m_zero;
  logic        exp_done, exp_err;
  logic [15:0] exp_data;

  // Reference model: m_cnt counts the cycles left until a legal op completes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_regs[i] <= '0;
      m_cnt <= 0; m_dst <= '0; m_result <= '0;
      m_in1 <= '0; m_in2 <= '0; m_op <= '0; m_zero <= 1'b0;
      exp_done <= 1'b0; exp_err <= 1'b0; exp_data <= '0;
    end else begin
      exp_done <= 1'b0;
      exp_err  <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_regs[m_dst] <= m_result;
          exp_done <= 1'b1;
          exp_data <= m_result;
          m_zero   <= (m_result == 16'd0);
        end
      end else if (ld_en) begin
        m_regs[ld_addr] <= ld_data;
      end else if (req_valid) begin
        if (req_op <= 3'd4) begin
          m_cnt    <= 3;
          m_dst    <= req_dst;
          m_in1    <= m_regs[req_src1];
          m_in2    <= m_regs[req_src2];
          m_op     <= req_op;
          m_result <= alu_fn(req_op, m_regs[req_src1], m_regs[req_src2]);
        end else begin
          exp_done <= 1'b1;
          exp_err  <= 1'b1;
          exp_data <= '0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  int          done_cyc_q[$];
  logic [15:0] done_data_q[$];

  // Per-cycle compare of every observable output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("req_ready", 32'(req_ready), 32'(m_cnt == 0 && !ld_en));
      checkOutput("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        checkOutput("done_err", 32'(done_err), 32'(exp_err));
        checkOutput("done_data", 32'(done_data), 32'(exp_data));
      end
      checkOutput("zero_flag", 32'(zero_flag), 32'(m_zero));
      checkOutput("alu_in1", 32'(alu_in1), 32'(m_in1));
      checkOutput("alu_in2", 32'(alu_in2), 32'(m_in2));
      checkOutput("alu_op", 32'(alu_op), 32'(m_op));
      if (done) begin
        done_cyc_q.push_back(cyc);
        done_data_q.push_back(done_data);
      end
    end
  end

  // Present one request and wait for it to be accepted; returns #1 after the accept edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] dst,
                               input logic [2:0] s1, input logic [2:0] s2,
                               input bit hold, output int acc_cyc);
    bit ok;
    ok = 0;
    req_op = op; req_dst = dst; req_src1 = s1; req_src2 = s2; req_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("[TB] FAIL accept_timeout actual=0 expected=1");
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic waitDone(output logic [15:0] data, output logic err, output int dcyc);
    bit ok;
    ok = 0; data = '0; err = 1'b0; dcyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; data = done_data; err = done_err; dcyc = cyc; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("[TB] FAIL done_timeout actual=0 expected=1");
    end
  endtask

  task automatic loadReg(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic readReg(input logic [2:0] a, output logic [15:0] d);
    int ac, dc;
    logic e;
    applyStimulus(3'd0, a, a, 3'd0, 1'b0, ac);
    waitDone(d, e, dc);
  endtask

  initial begin
    int          ac, ac2, ac3, dc, lc;
    logic [15:0] d;
    logic        e;

    // Reset and reset-state values.
    #1 rst_n = 1'b0;
    #21;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_alu_in1", 32'(alu_in1), 32'd0);
    checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("rst_zero_flag", 32'(zero_flag), 32'd0);
    checkOutput("rst_done_data", 32'(done_data), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add with latency and readback.
    loadReg(3'd1, 16'd5);
    loadReg(3'd2, 16'd3);
    applyStimulus(3'd1, 3'd0, 3'd1, 3'd2, 1'b0, ac);
    waitDone(d, e, dc);
    checkOutput("add_data", 32'(d), 32'd8);
    checkOutput("add_latency", 32'(dc - ac), 32'd3);
    checkOutput("add_zero", 32'(zero_flag), 32'd0);
    readReg(3'd0, d);
    checkOutput("r0_readback", 32'(d), 32'd8);

    // Zero result, then illegal op holds the flag, then a nonzero result clears it.
    applyStimulus(3'd2, 3'd3, 3'd1, 3'd1, 1'b0, ac);
    waitDone(d, e, dc);
    checkOutput("sub_data", 32'(d), 32'd0);
    checkOutput("sub_zero", 32'(zero_flag), 32'd1);
    applyStimulus(3'd6, 3'd2, 3'd1, 3'd1, 1'b0, ac);
    waitDone(d, e, dc);
    checkOutput("illegal_err", 32'(e), 32'd1);
    checkOutput("illegal_latency", 32'(dc - ac), 32'd0);
    checkOutput("illegal_alu_op", 32'(alu_op), 32'd2);
    checkOutput("illegal_zero_held", 32'(zero_flag), 32'd1);
    readReg(3'd2, d);
    checkOutput("illegal_no_write", 32'(d), 32'd3);
    applyStimulus(3'd1, 3'd7, 3'd1, 3'd2, 1'b0, ac);
    waitDone(d, e, dc);
    checkOutput("zero_cleared", 32'(zero_flag), 32'd0);

    // Chained ops with req_valid held high throughout.
    @(posedge clk); #1;
    done_cyc_q.delete(); done_data_q.delete();
    applyStimulus(3'd3, 3'd4, 3'd1, 3'd2, 1'b1, ac);
    applyStimulus(3'd4, 3'd5, 3'd4, 3'd2, 1'b1, ac2);
    applyStimulus(3'd2, 3'd6, 3'd5, 3'd1, 1'b0, ac3);
    waitDone(d, e, dc);
    @(posedge clk); #1;
    checkOutput("chain_spacing1", 32'(ac2 - ac), 32'd4);
    checkOutput("chain_spacing2", 32'(ac3 - ac2), 32'd4);
    checkOutput("chain_count", 32'(done_data_q.size()), 32'd3);
    if (done_data_q.size() == 3) begin
      checkOutput("chain_mul", 32'(done_data_q[0]), 32'd15);
      checkOutput("chain_shl", 32'(done_data_q[1]), 32'd120);
      checkOutput("chain_sub", 32'(done_data_q[2]), 32'd115);
      checkOutput("chain_done_gap", 32'(done_cyc_q[2] - done_cyc_q[1]), 32'd4);
    end

    // Load and request together: load wins, request accepted next cycle with the new value.
    ld_en = 1'b1; ld_addr = 3'd7; ld_data = 16'h1234;
    req_op = 3'd0; req_dst = 3'd0; req_src1 = 3'd7; req_src2 = 3'd0; req_valid = 1'b1;
    @(negedge clk);
    checkOutput("ld_blocks_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    lc = cyc;
    ld_en = 1'b0;
    applyStimulus(3'd0, 3'd0, 3'd7, 3'd0, 1'b0, ac);
    checkOutput("accept_after_load", 32'(ac - lc), 32'd1);
    waitDone(d, e, dc);
    checkOutput("loaded_value", 32'(d), 32'h1234);

    // Load during WAIT1 is ignored.
    applyStimulus(3'd1, 3'd0, 3'd1, 3'd2, 1'b0, ac);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'd99;
    @(posedge clk); #1;
    ld_en = 1'b0;
    waitDone(d, e, dc);
    checkOutput("wait1_add", 32'(d), 32'd8);
    readReg(3'd1, d);
    checkOutput("wait1_ld_ignored", 32'(d), 32'd5);

    // Reset during WAIT1 aborts and clears everything.
    applyStimulus(3'd1, 3'd0, 3'd1, 3'd2, 1'b0, ac);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_alu_in1", 32'(alu_in1), 32'd0);
    checkOutput("abort_alu_op", 32'(alu_op), 32'd0);
    checkOutput("abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk); @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 8; r++) begin
      readReg(3'(r), d);
      checkOutput("cleared_reg", 32'(d), 32'd0);
    end

    // Random phase, checked by the compare process against the model.
    for (int r = 1; r < 8; r++) loadReg(3'(r), 16'($urandom));
    for (int i = 0; i < 600; i++) begin
      ld_en     = ($urandom_range(7, 0) == 0);
      ld_addr   = 3'($urandom_range(7, 0));
      ld_data   = 16'($urandom_range(3, 0) == 0 ? 0 : $urandom);
      req_valid = ($urandom_range(3, 0) != 0);
      req_op    = ($urandom_range(4, 0) == 0) ? 3'($urandom_range(7, 5)) : 3'($urandom_range(4, 0));
      req_dst   = 3'($urandom_range(7, 0));
      req_src1  = 3'($urandom_range(7, 0));
      req_src2  = 3'($urandom_range(7, 0));
      @(posedge clk); #1;
    end
    req_valid = 1'b0; ld_en = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
